// File: rtl/comb_logic_unpack_pkg.sv
// Shared width defaults for the 128:70 capacitor-switch unpack path.
package comb_logic_unpack_pkg;

  localparam int unsigned CHANNEL_NUM_DEF   = 128;
  localparam int unsigned CAPACITOR_NUM_DEF = 70;
  // clog2(CAPACITOR_NUM_DEF + 1)
  localparam int unsigned CNT_W_DEF         = 7;

endpackage

// File: rtl/unpack_scatter.sv
// Combinational scatter: active capacitor j drives channel bit pre[j].
module unpack_scatter
  import comb_logic_unpack_pkg::*;
#(
  parameter int unsigned CHANNEL_NUM   = CHANNEL_NUM_DEF,
  parameter int unsigned CAPACITOR_NUM = CAPACITOR_NUM_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic [CAPACITOR_NUM-1:0]            cap,
  input  logic [CAPACITOR_NUM-1:0]            sw,
  input  logic [CAPACITOR_NUM-1:0][CNT_W-1:0] pre,
  output logic [CHANNEL_NUM-1:0]              chan
);

  for (genvar j = 0; j < CAPACITOR_NUM; j++) begin : gen_cap
    logic [CHANNEL_NUM-1:0] onehot;
    logic [CHANNEL_NUM-1:0] contrib;
    logic [CHANNEL_NUM-1:0] acc;

    assign onehot  = {{(CHANNEL_NUM-1){1'b0}}, 1'b1} << pre[j];
    // Inactive capacitors contribute nothing, whatever their data bit.
    assign contrib = (sw[j] && cap[j]) ? onehot : '0;

    if (j == 0) begin : gen_first
      assign acc = contrib;
    end else begin : gen_rest
      assign acc = gen_cap[j-1].acc | contrib;
    end
  end

  assign chan = gen_cap[CAPACITOR_NUM-1].acc;

endmodule

// File: rtl/comb_logic_unpack.sv
// Two-stage valid/ready pipeline scattering capacitor-domain words back into channel order.
module comb_logic_unpack
  import comb_logic_unpack_pkg::*;
#(
  parameter int unsigned CHANNEL_NUM   = CHANNEL_NUM_DEF,
  parameter int unsigned CAPACITOR_NUM = CAPACITOR_NUM_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_load,
  input  logic [CAPACITOR_NUM-1:0] cfg_sw,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CAPACITOR_NUM-1:0] cap_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHANNEL_NUM-1:0]   chan_out,
  output logic [CNT_W-1:0]         active_cnt
);

  logic [CAPACITOR_NUM-1:0]            sw_q;
  logic [CNT_W-1:0]                    active_cnt_q;
  logic [CAPACITOR_NUM-1:0][CNT_W-1:0] pre_d;
  logic [CNT_W-1:0]                    pop_d;

  logic                                s1_valid_q;
  logic [CAPACITOR_NUM-1:0]            s1_cap_q;
  logic [CAPACITOR_NUM-1:0]            s1_sw_q;
  logic [CAPACITOR_NUM-1:0][CNT_W-1:0] s1_pre_q;

  logic                                s2_valid_q;
  logic [CHANNEL_NUM-1:0]              chan_q;
  logic [CHANNEL_NUM-1:0]              scatter_chan;
  logic                                s2_en;

  // Exclusive prefix popcount of sw_q; pop_d ends as the full popcount.
  always_comb begin
    pop_d = '0;
    pre_d = '0;
    for (int unsigned j = 0; j < CAPACITOR_NUM; j++) begin
      pre_d[j] = pop_d;
      pop_d    = pop_d + CNT_W'(sw_q[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q         <= '1;
      active_cnt_q <= CNT_W'(CAPACITOR_NUM);
    end else begin
      if (cfg_load) begin
        sw_q <= cfg_sw;
      end
      active_cnt_q <= pop_d;
    end
  end

  assign s2_en    = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;

  // Stage 1 snapshots sw_q as it stands in the accept cycle, so a
  // concurrent cfg_load only affects later beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_cap_q   <= '0;
      s1_sw_q    <= '0;
      s1_pre_q   <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_cap_q <= cap_in;
        s1_sw_q  <= sw_q;
        s1_pre_q <= pre_d;
      end
    end
  end

  unpack_scatter #(
    .CHANNEL_NUM   (CHANNEL_NUM),
    .CAPACITOR_NUM (CAPACITOR_NUM),
    .CNT_W         (CNT_W)
  ) u_unpack_scatter (
    .cap  (s1_cap_q),
    .sw   (s1_sw_q),
    .pre  (s1_pre_q),
    .chan (scatter_chan)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      chan_q     <= '0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        chan_q <= scatter_chan;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign chan_out   = chan_q;
  assign active_cnt = active_cnt_q;

endmodule

// File: tb/tb_comb_logic_unpack.sv
// Scoreboard bench for comb_logic_unpack: model results queued at accept, compared at output.
module tb_comb_logic_unpack;

  localparam int unsigned CH  = 128;
  localparam int unsigned CAP = 70;
  localparam int unsigned CW  = 7;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_load;
  logic [CAP-1:0] cfg_sw;
  logic           in_valid;
  logic           in_ready;
  logic [CAP-1:0] cap_in;
  logic           out_valid;
  logic           out_ready;
  logic [CH-1:0]  chan_out;
  logic [CW-1:0]  active_cnt;

  int checks   = 0;
  int errors   = 0;
  int rx_count = 0;

  logic [CH-1:0]  exp_q[$];
  logic [CH-1:0]  mon_want;
  logic [CAP-1:0] sw_model;

  always #5 clk = ~clk;

  comb_logic_unpack dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_load   (cfg_load),
    .cfg_sw     (cfg_sw),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cap_in     (cap_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .chan_out   (chan_out),
    .active_cnt (active_cnt)
  );

  function automatic logic [CH-1:0] model(input logic [CAP-1:0] cap, input logic [CAP-1:0] sw);
    int k;
    model = '0;
    k = 0;
    for (int j = 0; j < CAP; j++) begin
      if (sw[j]) begin
        model[k] = cap[j];
        k++;
      end
    end
  endfunction

  // Scoreboard: push at accept (using the switch map in force that cycle), pop on transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      sw_model = '1;
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %h with empty scoreboard", chan_out);
        end else begin
          mon_want = exp_q.pop_front();
          rx_count++;
          if (chan_out !== mon_want) begin
            errors++;
            $display("FAIL scoreboard_data: got %h want %h", chan_out, mon_want);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(cap_in, sw_model));
      if (cfg_load) sw_model = cfg_sw;
    end
  end

  task automatic drive_beat(input logic [CAP-1:0] cap);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    cap_in   = cap;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic [CAP-1:0] sw);
    @(posedge clk); #1;
    cfg_load = 1'b1;
    cfg_sw   = sw;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (chan_out !== '0) begin
      errors++; $display("FAIL reset_chan_out: got %h want 0", chan_out);
    end
    checks++;
    if (active_cnt !== 7'd70) begin
      errors++; $display("FAIL reset_active_cnt: got %0d want 70", active_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_default_map;
    logic [CAP-1:0] c;
    logic [CH-1:0]  want;
    c    = 70'h2A_AAAA_AAAA_AAAA_AAAA;
    want = '0;
    want[CAP-1:0] = c;
    drive_beat(c);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL latency_early: out_valid %b want 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || chan_out !== want) begin
      errors++;
      $display("FAIL default_map: valid %b chan %h want %h", out_valid, chan_out, want);
    end
    checks++;
    if (active_cnt !== 7'd70) begin
      errors++; $display("FAIL default_cnt: got %0d want 70", active_cnt);
    end
  endtask

  task automatic test_single_cap;
    logic [CAP-1:0] top;
    top = '0;
    top[CAP-1] = 1'b1;
    load_cfg(top);
    @(negedge clk);
    checks++;
    if (active_cnt !== 7'd1) begin
      errors++; $display("FAIL single_cnt: got %0d want 1", active_cnt);
    end
    drive_beat(top);
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || chan_out !== 128'h1) begin
      errors++; $display("FAIL single_hi: valid %b chan %h want 1", out_valid, chan_out);
    end
    drive_beat(70'h1);
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || chan_out !== 128'h0) begin
      errors++; $display("FAIL single_ignored: valid %b chan %h want 0", out_valid, chan_out);
    end
  endtask

  task automatic test_alternating;
    logic [CH-1:0] want;
    want = '0;
    want[34:0] = '1;
    load_cfg(70'h15_5555_5555_5555_5555);
    drive_beat('1);
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || chan_out !== want) begin
      errors++; $display("FAIL alternating: valid %b chan %h want %h", out_valid, chan_out, want);
    end
    checks++;
    if (active_cnt !== 7'd35) begin
      errors++; $display("FAIL alternating_cnt: got %0d want 35", active_cnt);
    end
  endtask

  task automatic test_zero_map;
    load_cfg('0);
    drive_beat('1);
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || chan_out !== '0 || active_cnt !== 7'd0) begin
      errors++;
      $display("FAIL zero_map: valid %b chan %h cnt %0d want 1/0/0", out_valid, chan_out, active_cnt);
    end
  endtask

  task automatic test_backpressure;
    int sent;
    int c;
    int rx0;
    int n;
    logic [CH-1:0] held;
    load_cfg('1);
    sent = 0;
    c    = 0;
    held = '0;
    rx0  = rx_count;
    while (sent < 10 && c < 100) begin
      @(posedge clk); #1;
      out_ready = !(c >= 4 && c <= 6);
      in_valid  = 1'b1;
      cap_in    = 70'(sent + 1);
      @(negedge clk);
      if (c == 4) held = chan_out;
      if (c >= 4 && c <= 6) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_in_ready: cycle %0d got %b want 0", c, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || chan_out !== held) begin
          errors++;
          $display("FAIL stall_hold: cycle %0d valid %b chan %h want %h", c, out_valid, chan_out,
                   held);
        end
      end
      if (in_ready) sent++;
      c++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (rx_count - rx0 != 10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL backpressure_count: got %0d left %0d want 10 left 0", rx_count - rx0,
               exp_q.size());
    end
  endtask

  task automatic test_reconfig_in_flight;
    logic [CAP-1:0] a;
    logic [CAP-1:0] b;
    logic [CH-1:0]  want_a;
    a = 70'h3_1234_5678_9ABC_DEF0;
    b = 70'h2_0000_0000_0000_0003;
    want_a = '0;
    want_a[CAP-1:0] = a;
    @(posedge clk); #1;
    in_valid = 1'b1;
    cap_in   = a;
    cfg_load = 1'b1;
    cfg_sw   = 70'h1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reconfig_ready_a: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    cfg_load = 1'b0;
    cap_in   = b;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reconfig_ready_b: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || chan_out !== want_a) begin
      errors++; $display("FAIL reconfig_a: valid %b chan %h want %h", out_valid, chan_out, want_a);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || chan_out !== 128'h1) begin
      errors++; $display("FAIL reconfig_b: valid %b chan %h want 1", out_valid, chan_out);
    end
    @(negedge clk);
    checks++;
    if (active_cnt !== 7'd1) begin
      errors++; $display("FAIL reconfig_cnt: got %0d want 1", active_cnt);
    end
  endtask

  task automatic test_reset_mid_stream;
    logic [CAP-1:0] c;
    logic [CH-1:0]  want;
    out_ready = 1'b0;
    drive_beat(70'h0_0000_0000_0000_00FF);
    drive_beat(70'h0_0000_0000_0000_0F0F);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL full_stall: in_ready %b out_valid %b want 0/1", in_ready, out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || active_cnt !== 7'd70) begin
      errors++;
      $display("FAIL mid_reset: valid %b ready %b cnt %0d want 0/1/70", out_valid, in_ready,
               active_cnt);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL stale_out: cycle %0d valid %b want 0", i, out_valid);
      end
    end
    c    = 70'h1_2345_6789_ABCD_EF01;
    want = '0;
    want[CAP-1:0] = c;
    drive_beat(c);
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || chan_out !== want) begin
      errors++; $display("FAIL sw_after_reset: valid %b chan %h want %h", out_valid, chan_out, want);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cfg_load  = 1'b0;
    cfg_sw    = '0;
    in_valid  = 1'b0;
    cap_in    = '0;
    out_ready = 1'b1;
    sw_model  = '1;

    test_reset();
    test_default_map();
    test_single_cap();
    test_alternating();
    test_zero_map();
    test_backpressure();
    test_reconfig_in_flight();
    test_reset_mid_stream();

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL final_drain: %0d words outstanding want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
